pipe_stall_ctrl: RTL and testbench

//  Parametrised successor to the core's combinational stall controller. Merges per-stage stall

---
 rtl/pipe_stall_ctrl_pkg.sv | 23 ++
 rtl/pipe_stall_ctrl_mc_counter.sv | 27 ++
 rtl/pipe_stall_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
package pipe_stall_ctrl_pkg;

  // Default geometry of the five-stage core
  localparam int NUM_STAGES_DEF = 5;
  localparam int MC_CNT_W_DEF   = 6;
  localparam int PC_W_DEF       = 32;

  // Stage indices
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MULTI = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stall_ctrl_mc_counter.sv
// Multi-cycle latency counter: load / saturating decrement / abort, with a
// flag that marks the op's final held cycle.
module pipe_stall_ctrl_mc_counter #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  input  logic         i_abort,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  // Abort beats load beats decrement; decrement saturates at zero
  always_ff @(posedge i_clk) begin
    if (i_rst)                   r_cnt <= '0;
    else if (i_abort)            r_cnt <= '0;
    else if (i_load)             r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges per-stage stall requests, EX multi-cycle
// holds and MEM flush/redirect into one stall bus plus a registered flush.
// Optional feature macro: PIPE_PERF_CNT_EN adds stall-cycle and flush counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int MC_CNT_W   = MC_CNT_W_DEF,
  parameter int PC_W       = PC_W_DEF,
  parameter int EX_IDX     = STG_EX
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_STAGES-1:0] i_stallreq,
  input  logic                  i_mc_start,
  input  logic [MC_CNT_W-1:0]   i_mc_cycles,
  input  logic                  i_flush_req,
  input  logic [PC_W-1:0]       i_flush_pc,
  output logic [NUM_STAGES:0]   o_stall,
  output logic                  o_mc_busy,
  output logic                  o_mc_done,
  output logic                  o_flush,
  output logic [PC_W-1:0]       o_new_pc
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]           o_perf_stall_cyc,
  output logic [31:0]           o_perf_flush_cnt
`endif
);

  state_t                r_state, w_state_nxt;
  logic [PC_W-1:0]       r_new_pc;
  logic                  w_ex_hold, w_mc_done, w_stall_kill, w_pc_ld;
  logic                  w_cnt_load, w_cnt_dec, w_cnt_abort, w_cnt_last;
  logic [NUM_STAGES-1:0] w_eff;
  logic [NUM_STAGES:0]   w_stall_raw;

  // Counter holds the held cycles still to come after the start cycle, so
  // an N-cycle op loads N-1 and the final held cycle is the one with count 1.
  pipe_stall_ctrl_mc_counter #(.W(MC_CNT_W)) u_mc_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_cnt_load),
    .i_load_val (i_mc_cycles - 1'b1),
    .i_dec      (w_cnt_dec),
    .i_abort    (w_cnt_abort),
    .o_last     (w_cnt_last)
  );

  // State and redirect-target registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_RUN;
      r_new_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pc_ld) r_new_pc <= i_flush_pc;
    end
  end

  // Next state and control: flush_req outranks mc_start, which outranks stallreq
  always_comb begin
    w_state_nxt  = r_state;
    w_ex_hold    = 1'b0;
    w_mc_done    = 1'b0;
    w_stall_kill = 1'b0;
    w_pc_ld      = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_cnt_abort  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_flush_req) begin
          w_pc_ld      = 1'b1;
          w_stall_kill = 1'b1;
          w_state_nxt  = ST_FLUSH;
        end else if (i_mc_start) begin
          if (i_mc_cycles == '0) begin
            w_mc_done = 1'b1;
          end else if (i_mc_cycles == MC_CNT_W'(1)) begin
            w_ex_hold = 1'b1;
            w_mc_done = 1'b1;
          end else begin
            w_ex_hold   = 1'b1;
            w_cnt_load  = 1'b1;
            w_state_nxt = ST_MULTI;
          end
        end
      end
      ST_MULTI: begin
        if (i_flush_req) begin
          w_cnt_abort  = 1'b1;
          w_pc_ld      = 1'b1;
          w_stall_kill = 1'b1;
          w_state_nxt  = ST_FLUSH;
        end else begin
          // Done cycle is still held; the result is consumed the cycle after
          w_ex_hold = 1'b1;
          w_cnt_dec = 1'b1;
          if (w_cnt_last) begin
            w_mc_done   = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        w_stall_kill = 1'b1;
        w_state_nxt  = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Priority encode: highest requesting stage s holds stages 0..s+1
  assign w_eff          = i_stallreq | (NUM_STAGES'(w_ex_hold) << EX_IDX);
  assign w_stall_raw[0] = |w_eff;
  for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stall
    assign w_stall_raw[k] = |w_eff[NUM_STAGES-1:k-1];
  end

  assign o_stall   = w_stall_kill ? '0 : w_stall_raw;
  assign o_mc_busy = (r_state == ST_MULTI);
  assign o_mc_done = w_mc_done;
  assign o_flush   = (r_state == ST_FLUSH);
  assign o_new_pc  = r_new_pc;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_perf_stall_cyc, r_perf_flush_cnt;

  // Free-running performance counters, wrapping at 2**32
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_stall_cyc <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (o_stall[0]) r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
      if (o_flush)    r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign o_perf_stall_cyc = r_perf_stall_cyc;
  assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios then random
// traffic against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  stallreq;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        mc_busy, mc_done, flush;
  logic [31:0] new_pc;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_left;      // held cycles of the current op still to come
  bit          m_flush_nxt; // flush pulse due in the coming cycle
  logic [31:0] m_pc;
  int unsigned m_perf_stall, m_perf_flush;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_stallreq  (stallreq),
    .i_mc_start  (mc_start),
    .i_mc_cycles (mc_cycles),
    .i_flush_req (flush_req),
    .i_flush_pc  (flush_pc),
    .o_stall     (stall),
    .o_mc_busy   (mc_busy),
    .o_mc_done   (mc_done),
    .o_flush     (flush),
    .o_new_pc    (new_pc)
`ifdef PIPE_PERF_CNT_EN
    ,
    .o_perf_stall_cyc (perf_stall_cyc),
    .o_perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // Expected stall bus: highest requesting stage s -> bits s+1..0 set
  function automatic logic [5:0] stall_of(input logic [4:0] req);
    int s = -1;
    for (int i = 0; i < 5; i++) if (req[i]) s = i;
    if (s < 0) return 6'd0;
    return 6'((1 << (s + 2)) - 1);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check just after, advance model
  task automatic step(input logic r, input logic [4:0] sr, input logic ms,
                      input logic [5:0] mcc, input logic fr, input logic [31:0] fpc);
    logic [5:0] e_stall;
    logic       e_busy, e_done, e_flush, hold, chk_stall, nf;
    @(negedge clk);
    rst = r; stallreq = sr; mc_start = ms; mc_cycles = mcc; flush_req = fr; flush_pc = fpc;
    #1;
    if (r) begin
      m_left = 0; m_flush_nxt = 0; m_pc = '0; m_perf_stall = 0; m_perf_flush = 0;
      return;
    end
    e_flush = m_flush_nxt; e_busy = 0; e_done = 0; hold = 0; chk_stall = 1; nf = 0;
    e_stall = '0;
    if (!m_flush_nxt) begin
      e_busy = (m_left > 0);
      if (fr) begin
        nf = 1; m_pc = fpc; m_left = 0; chk_stall = 0;
      end else if (m_left > 0) begin
        hold = 1; e_done = (m_left == 1); m_left--;
      end else if (ms) begin
        if (mcc == 0) e_done = 1;
        else begin hold = 1; e_done = (mcc == 1); m_left = int'(mcc) - 1; end
      end
      e_stall = stall_of(sr | {2'b00, hold, 2'b00});
    end
    if (chk_stall) begin
      checks++;
      assert (stall === e_stall) else begin
        errors++;
        $error("FAIL stall obs=%b exp=%b", stall, e_stall);
      end
    end
    chk1("mc_busy", mc_busy, e_busy);
    chk1("mc_done", mc_done, e_done);
    chk1("flush", flush, e_flush);
    if (e_flush) chk32("new_pc", new_pc, m_pc);
`ifdef PIPE_PERF_CNT_EN
    chk32("perf_stall", perf_stall_cyc, m_perf_stall);
    chk32("perf_flush", perf_flush_cnt, m_perf_flush);
`endif
    if (chk_stall && e_stall[0]) m_perf_stall++;
    if (e_flush) m_perf_flush++;
    m_flush_nxt = nf;
  endtask

  initial begin
    rst = 1; stallreq = 0; mc_start = 0; mc_cycles = 0; flush_req = 0; flush_pc = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Reset state
    step(0, 0, 0, 0, 0, 0);
    chk32("reset_new_pc", new_pc, 32'h0);
    // 1: ID load-use, then release
    step(0, 5'b00010, 0, 0, 0, 0);
    step(0, 5'b00000, 0, 0, 0, 0);
    // 2: ID+EX, EX dominates
    step(0, 5'b00110, 0, 0, 0, 0);
    step(0, 5'b00000, 0, 0, 0, 0);
    // 3: four-cycle op
    step(0, 0, 1, 6'd4, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    // 4: zero-latency op
    step(0, 0, 1, 6'd0, 0, 0);
    // one-cycle op, and WB request over a hold
    step(0, 0, 1, 6'd1, 0, 0);
    step(0, 5'b10000, 1, 6'd3, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    // 5: flush during MULTI, back-to-back flush_req dropped
    step(0, 0, 1, 6'd5, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hBFC00380);
    step(0, 5'b00001, 1, 6'd3, 1, 32'h12345678);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // maximum latency op
    step(0, 0, 1, 6'd63, 0, 0);
    repeat (64) step(0, 0, 0, 0, 0, 0);
    // 6: reset mid-MULTI
    step(0, 0, 1, 6'd6, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // reset mid-FLUSH
    step(0, 0, 0, 0, 1, 32'hDEAD0000);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0,
           ($urandom_range(0, 5) == 0),
           6'($urandom_range(0, 9)),
           ($urandom_range(0, 24) == 0),
           $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
